// File: rtl/jtag_tap_sampled.sv
// JTAG TAP that oversamples tck/tms/tdi on clk and offers IDCODE, BYPASS and one USER register.
// Optional trst_n input (synchronized) is enabled by defining JTAG_TAP_TRST_EN.
module jtag_tap_sampled #(
  parameter int unsigned            IR_WIDTH     = 4,
  parameter int unsigned            DR_WIDTH     = 32,
  parameter logic [31:0]            IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0]    IDCODE_INSTR = 4'b0010,
  parameter logic [IR_WIDTH-1:0]    USER_INSTR   = 4'b1000,
  parameter int unsigned            SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
`ifdef JTAG_TAP_TRST_EN
  input  logic                trst_n,
`endif
  output logic                tdo,
  output logic                tdo_oe,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [DR_WIDTH-1:0] user_dr_in,
  output logic [DR_WIDTH-1:0] user_dr_out,
  output logic                user_dr_valid
);

  localparam int unsigned DrW  = (DR_WIDTH > 32) ? DR_WIDTH : 32;
  localparam int unsigned CntW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [3:0] {
    StTlr   = 4'hF, StRti   = 4'hC, StSelDr = 4'h7, StCapDr = 4'h6,
    StShDr  = 4'h2, StEx1Dr = 4'h1, StPauDr = 4'h3, StEx2Dr = 4'h0,
    StUpdDr = 4'h5, StSelIr = 4'h4, StCapIr = 4'hE, StShIr  = 4'hA,
    StEx1Ir = 4'h9, StPauIr = 4'hB, StEx2Ir = 4'h8, StUpdIr = 4'hD
  } tap_state_e;

  logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
  logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
  logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
  logic                   tck_hist_q;
  logic [CntW-1:0]        mask_cnt_q, mask_cnt_d;
  tap_state_e             state_q, state_d, state_next;
  logic [IR_WIDTH-1:0]    ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0]    ir_out_q, ir_out_d;
  logic [DrW-1:0]         dr_shift_q, dr_shift_d;
  logic                   tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic [DR_WIDTH-1:0]    user_dr_out_q, user_dr_out_d;
  logic                   user_dr_valid_q, user_dr_valid_d;
  logic                   tck_s, tms_s, tdi_s, rise, fall, trst_act;
  logic                   sel_idcode, sel_user;

`ifdef JTAG_TAP_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync_q, trst_sync_d;
  assign trst_sync_d = {trst_sync_q[SYNC_STAGES-2:0], trst_n};
  assign trst_act    = ~trst_sync_q[SYNC_STAGES-1];
`else
  assign trst_act    = 1'b0;
`endif

  assign tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], tck};
  assign tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], tms};
  assign tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], tdi};
  assign tck_s      = tck_sync_q[SYNC_STAGES-1];
  assign tms_s      = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s      = tdi_sync_q[SYNC_STAGES-1];

  // Masking after reset hides the edge produced while the synchronizer refills.
  assign mask_cnt_d = (mask_cnt_q != '0) ? mask_cnt_q - 1'b1 : '0;
  assign rise = tck_s & ~tck_hist_q & (mask_cnt_q == '0) & ~trst_act;
  assign fall = ~tck_s & tck_hist_q & (mask_cnt_q == '0) & ~trst_act;

  assign sel_idcode = (ir_out_q == IDCODE_INSTR);
  assign sel_user   = (ir_out_q == USER_INSTR);

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      StTlr:   state_next = tms_s ? StTlr   : StRti;
      StRti:   state_next = tms_s ? StSelDr : StRti;
      StSelDr: state_next = tms_s ? StSelIr : StCapDr;
      StCapDr: state_next = tms_s ? StEx1Dr : StShDr;
      StShDr:  state_next = tms_s ? StEx1Dr : StShDr;
      StEx1Dr: state_next = tms_s ? StUpdDr : StPauDr;
      StPauDr: state_next = tms_s ? StEx2Dr : StPauDr;
      StEx2Dr: state_next = tms_s ? StUpdDr : StShDr;
      StUpdDr: state_next = tms_s ? StSelDr : StRti;
      StSelIr: state_next = tms_s ? StTlr   : StCapIr;
      StCapIr: state_next = tms_s ? StEx1Ir : StShIr;
      StShIr:  state_next = tms_s ? StEx1Ir : StShIr;
      StEx1Ir: state_next = tms_s ? StUpdIr : StPauIr;
      StPauIr: state_next = tms_s ? StEx2Ir : StPauIr;
      StEx2Ir: state_next = tms_s ? StUpdIr : StShIr;
      StUpdIr: state_next = tms_s ? StSelDr : StRti;
      default: state_next = StTlr;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    ir_shift_d      = ir_shift_q;
    ir_out_d        = ir_out_q;
    dr_shift_d      = dr_shift_q;
    tdo_d           = tdo_q;
    tdo_oe_d        = tdo_oe_q;
    user_dr_out_d   = user_dr_out_q;
    user_dr_valid_d = 1'b0;
    if (trst_act) begin
      state_d  = StTlr;
      ir_out_d = IDCODE_INSTR;
      tdo_d    = 1'b0;
      tdo_oe_d = 1'b0;
    end else if (rise) begin
      if (state_q == StCapIr) begin
        ir_shift_d = IR_WIDTH'(1);
      end else if (state_q == StShIr) begin
        ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
      end else if (state_q == StCapDr) begin
        if (sel_user)        dr_shift_d[DR_WIDTH-1:0] = user_dr_in;
        else if (sel_idcode) dr_shift_d[31:0] = IDCODE_VALUE;
        else                 dr_shift_d[0] = 1'b0;
      end else if (state_q == StShDr) begin
        // Shift length follows the selected register: DR_WIDTH, 32 or 1.
        if (sel_user)        dr_shift_d[DR_WIDTH-1:0] = {tdi_s, dr_shift_q[DR_WIDTH-1:1]};
        else if (sel_idcode) dr_shift_d[31:0] = {tdi_s, dr_shift_q[31:1]};
        else                 dr_shift_d[0] = tdi_s;
      end
      state_d = state_next;
      if (state_next == StTlr) ir_out_d = IDCODE_INSTR;
    end else if (fall) begin
      if (state_q == StShIr) begin
        tdo_d    = ir_shift_q[0];
        tdo_oe_d = 1'b1;
      end else if (state_q == StShDr) begin
        tdo_d    = dr_shift_q[0];
        tdo_oe_d = 1'b1;
      end else begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
      end
      if (state_q == StUpdIr) ir_out_d = ir_shift_q;
      if (state_q == StUpdDr && sel_user) begin
        user_dr_out_d   = dr_shift_q[DR_WIDTH-1:0];
        user_dr_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_q      <= '0;
      tms_sync_q      <= '0;
      tdi_sync_q      <= '0;
      tck_hist_q      <= 1'b0;
      mask_cnt_q      <= CntW'(SYNC_STAGES + 1);
      state_q         <= StTlr;
      ir_shift_q      <= '0;
      ir_out_q        <= IDCODE_INSTR;
      dr_shift_q      <= '0;
      tdo_q           <= 1'b0;
      tdo_oe_q        <= 1'b0;
      user_dr_out_q   <= '0;
      user_dr_valid_q <= 1'b0;
    end else begin
      tck_sync_q      <= tck_sync_d;
      tms_sync_q      <= tms_sync_d;
      tdi_sync_q      <= tdi_sync_d;
      tck_hist_q      <= tck_s;
      mask_cnt_q      <= mask_cnt_d;
      state_q         <= state_d;
      ir_shift_q      <= ir_shift_d;
      ir_out_q        <= ir_out_d;
      dr_shift_q      <= dr_shift_d;
      tdo_q           <= tdo_d;
      tdo_oe_q        <= tdo_oe_d;
      user_dr_out_q   <= user_dr_out_d;
      user_dr_valid_q <= user_dr_valid_d;
    end
  end

`ifdef JTAG_TAP_TRST_EN
  always_ff @(posedge clk) begin
    if (rst) trst_sync_q <= '0;
    else     trst_sync_q <= trst_sync_d;
  end
`endif

  assign tdo           = tdo_q;
  assign tdo_oe        = tdo_oe_q;
  assign tap_state     = state_q;
  assign ir_out        = ir_out_q;
  assign user_dr_out   = user_dr_out_q;
  assign user_dr_valid = user_dr_valid_q;

endmodule

// File: doc/jtag_tap_sampled.md
Name: jtag_tap_sampled

Overview:
- Synthesizable JTAG target (TAP) for the far end of the jtag_vpi link.
- Oversamples tck/tms/tdi on the system clock, runs the IEEE 1149.1 16-state TAP FSM and drives tdo.
- Instructions: IDCODE, BYPASS and one USER data register, exposed to core logic as a parallel word plus an update strobe.
- Sits in the DUT top level, wired directly to the testbench JTAG driver pins.

Parameters:
- IR_WIDTH, 4, instruction register width.
- DR_WIDTH, 32, USER data register width.
- IDCODE_VALUE, 32'h149511C3, value captured in IDCODE; bit 0 must be 1.
- IDCODE_INSTR, 4'b0010, IDCODE opcode.
- USER_INSTR, 4'b1000, USER opcode; all-ones is BYPASS; any unlisted opcode selects BYPASS.
- SYNC_STAGES, 2, synchronizer depth on tck/tms/tdi, minimum 2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- tck, input, 1, JTAG clock (asynchronous to clk).
- tms, input, 1, JTAG mode select.
- tdi, input, 1, JTAG data in.
- tdo, output, 1, JTAG data out.
- tdo_oe, output, 1, high while tdo is driven (Shift-IR/Shift-DR).
- tap_state, output, 4, current TAP state encoding.
- ir_out, output, IR_WIDTH, active instruction.
- user_dr_in, input, DR_WIDTH, parallel value captured in Capture-DR under USER.
- user_dr_out, output, DR_WIDTH, value latched in Update-DR under USER.
- user_dr_valid, output, 1, one-clk pulse when user_dr_out updates.

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high (rst).
- Synchronizer: tck, tms and tdi each pass through SYNC_STAGES flops. Edges are detected on synced tck versus a 1-flop history:
  - rise: 0 then 1.
  - fall: 1 then 0.
  - tms/tdi used are the synced values from the same clk cycle as the detected edge.
- Timing requirement: TCK half period ≥ (SYNC_STAGES+2) clk periods; faster TCK is unsupported.
- State encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5.
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
  - Transitions per 1149.1, taken only on a rise cycle.
- On a rise cycle, with S = state before transition:
  - CapIR: ir_shift <= {0..0,01}.
  - ShIR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
  - CapDR: dr_shift loaded with IDCODE_VALUE (IDCODE), user_dr_in (USER), or 0 in bit 0 (BYPASS).
  - ShDR: right shift with tdi into the MSB of the selected register length (DR_WIDTH, 32, or 1).
  - Then state <= next(S, tms).
- On a fall cycle:
  - ShIR/ShDR: tdo <= shift reg bit 0, tdo_oe <= 1.
  - Any other state: tdo <= 0, tdo_oe <= 0.
  - UpdIR: ir_out <= ir_shift.
  - UpdDR with ir_out==USER_INSTR: user_dr_out <= dr_shift[DR_WIDTH-1:0], user_dr_valid pulses for that cycle.
- First TDO bit appears on the fall after entering a Shift state, so it is valid before the next TCK rise.
- Entering TLR (by any path): ir_out <= IDCODE_INSTR on the same cycle. user_dr_out is kept.
- Five rise cycles with tms=1 reach TLR from any state.
- Reset values:
  - state=TLR, ir_out=IDCODE_INSTR.
  - ir_shift=0, dr_shift=0.
  - tdo=0, tdo_oe=0.
  - user_dr_out=0, user_dr_valid=0.
  - Sync flops and tck history=0.
  - Edge detection masked for SYNC_STAGES+1 clk cycles after rst deasserts, which suppresses a false rise if tck is already high.
- Reset mid-shift: partial shift content is discarded; no update strobe is generated.
- Simultaneous rise and fall in one cycle is impossible by construction (single history flop).

Optional Feature:
- Macro: JTAG_TAP_TRST_EN.
- Defined: adds input trst_n (1 bit, active low). It passes through its own SYNC_STAGES synchronizer. While synced trst_n=0: state=TLR, ir_out=IDCODE_INSTR, tdo_oe=0, and edges are ignored. user_dr_out is kept.
- Undefined: no trst_n port; TLR is reached only via rst or TMS.

Test Plan:
- Reset, then 5 TCK with tms=1, 1 with tms=0 -> tap_state=C, ir_out=4'b0010.
- From RTI: TMS 1,0,0 to ShDR; shift 32 bits with tdi=0, last with tms=1 -> tdo stream LSB first = 32'h149511C3.
- Load IR 4'b1111 (ShIR), shift DR pattern 1,0,1,1 -> tdo = 0,1,0,1 (one-bit delay, leading 0).
- Load IR 4'b1000, user_dr_in=32'hCAFE0001, scan in 32'hDEADBEEF -> tdo shows 32'hCAFE0001; on UpdDR user_dr_out=32'hDEADBEEF and user_dr_valid high for exactly 1 clk.
- Capture-IR readout: shift 4 bits in ShIR -> tdo = 1,0,0,0 (LSB first, value 4'b0001); assert rst mid-ShDR -> tap_state=F, tdo_oe=0, no user_dr_valid pulse.
- With JTAG_TAP_TRST_EN: drive trst_n=0 while in PauDR -> tap_state=F within SYNC_STAGES+1 clk; TCK edges ignored until release.
